// File: rtl/mc_pkg.sv
// mc_pkg: state encoding, opcodes and datapath mux/ALU encodings for the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWR   = 4'd4,
    MEMWB   = 4'd5,
    EXECR   = 4'd6,
    EXECI   = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    JAL     = 4'd10,
    JALR    = 4'd11,
    JALRLNK = 4'd12,
    LUIWB   = 4'd13,
    TRAP    = 4'd14
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BR     = 2'b01;
  localparam logic [1:0] ALU_R      = 2'b10;
  localparam logic [1:0] ALU_I      = 2'b11;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_JU     = 2'b11;
endpackage

// File: rtl/mc_imm_decode.sv
// mc_imm_decode: combinational immediate-format select from opcode (Op in, ImmSrc out)
module mc_imm_decode
  import mc_pkg::*;
(
  input  logic [6:0] Op,
  output logic [1:0] ImmSrc
);
  always_comb
    ImmSrc = (Op == OP_STORE) ? IMM_S :
             (Op == OP_BRANCH) ? IMM_B :
             (Op == OP_JAL || Op == OP_LUI || Op == OP_AUIPC) ? IMM_JU : IMM_I;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle control FSM; inputs clk/rst/Op/BranchTaken/mem_ready, outputs datapath selects, strobes, retire, illegal, state
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic       BranchTaken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic       Branch,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);
  state_t state_q, state_d;
  mc_imm_decode u_imm (.Op(Op), .ImmSrc(ImmSrc));
  always_ff @(posedge clk)
    state_q <= rst ? FETCH : state_d;
  assign state = state_q;
  assign illegal = (state_q == TRAP);
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = mem_ready ? DECODE : FETCH;
      DECODE:  state_d = (Op == OP_LOAD || Op == OP_STORE) ? MEMADR :
                         (Op == OP_RTYPE) ? EXECR :
                         (Op == OP_ITYPE) ? EXECI :
                         (Op == OP_BRANCH) ? BRANCH :
                         (Op == OP_JAL) ? JAL :
                         (Op == OP_JALR) ? JALR :
                         (Op == OP_LUI) ? LUIWB :
                         (Op == OP_AUIPC) ? ALUWB : TRAP;
      MEMADR:  state_d = (Op == OP_LOAD) ? MEMRD : (Op == OP_STORE) ? MEMWR : TRAP;
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      EXECR,
      EXECI,
      JAL,
      JALRLNK: state_d = ALUWB;
      JALR:    state_d = JALRLNK;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end
  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_B;
    ALUOp     = ALU_ADD;
    ResultSrc = RES_ALUOUT;
    Branch    = 1'b0;
    retire    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ready;
      end
      MEMWB: begin
        ResultSrc = RES_MEM;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      EXECR: begin
        ALUSrcA = SRCA_A;
        ALUOp   = ALU_R;
      end
      EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_I;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = SRCA_A;
        ALUOp   = ALU_BR;
        Branch  = 1'b1;
        PCWrite = BranchTaken;
        retire  = 1'b1;
      end
      JAL: begin
        PCWrite = 1'b1;
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
      end
      JALR: begin
        ALUSrcA   = SRCA_A;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        PCWrite   = 1'b1;
      end
      JALRLNK: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
      end
      LUIWB: begin
        ResultSrc = RES_IMM;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      retire   = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench for multicycle_controller
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst, BranchTaken, mem_ready;
  logic [6:0] Op;
  logic mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, Branch, retire, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ImmSrc, ResultSrc;
  logic [3:0] state;
  int checks = 0;
  int failures = 0;
  multicycle_controller dut (
    .clk(clk), .rst(rst), .Op(Op), .BranchTaken(BranchTaken), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .Branch(Branch),
    .retire(retire), .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // strobes packed as {mem_req, IRWrite, PCWrite, RegWrite, retire}
  task automatic ctl(input string tag, input logic [3:0] st, input logic [4:0] strb);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".strobes"}, 32'({mem_req, IRWrite, PCWrite, RegWrite, retire}), 32'(strb));
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; Op = 7'b0; BranchTaken = 1'b0; mem_ready = 1'b0;
    tick;
    ctl("reset", 4'd0, 5'b00000);
    chk("reset.illegal", 32'(illegal), 0);
    chk("reset.memwrite", 32'(MemWrite), 0);
    rst = 1'b0; Op = 7'b0110011; mem_ready = 1'b1; #1;
    ctl("add.c1", 4'd0, 5'b11100);
    chk("add.c1.resultsrc", 32'(ResultSrc), 2);
    chk("add.c1.srcb", 32'(ALUSrcB), 2);
    tick; ctl("add.c2", 4'd1, 5'b00000);
    chk("add.c2.srca", 32'(ALUSrcA), 1);
    chk("add.c2.imm", 32'(ImmSrc), 0);
    tick; ctl("add.c3", 4'd6, 5'b00000);
    chk("add.c3.aluop", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'(6'b100010));
    tick; ctl("add.c4", 4'd8, 5'b00011);
    chk("add.c4.resultsrc", 32'(ResultSrc), 0);
    tick; Op = 7'b0000011; mem_ready = 1'b0; #1;
    ctl("lw.fwait1", 4'd0, 5'b10000);
    chk("lw.fwait1.adr", 32'(AdrSrc), 0);
    tick; ctl("lw.fwait2", 4'd0, 5'b10000);
    mem_ready = 1'b1; #1;
    ctl("lw.fetch", 4'd0, 5'b11100);
    tick; mem_ready = 1'b0; #1;
    ctl("lw.decode", 4'd1, 5'b00000);
    chk("lw.decode.imm", 32'(ImmSrc), 0);
    tick; ctl("lw.memadr", 4'd2, 5'b00000);
    chk("lw.memadr.sel", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'(6'b100100));
    tick; ctl("lw.rwait1", 4'd3, 5'b10000);
    chk("lw.rwait1.adr", 32'({AdrSrc, MemWrite}), 32'(2'b10));
    tick; ctl("lw.rwait2", 4'd3, 5'b10000);
    chk("lw.rwait2.adr", 32'({AdrSrc, MemWrite}), 32'(2'b10));
    mem_ready = 1'b1; #1;
    ctl("lw.memrd", 4'd3, 5'b10000);
    tick; ctl("lw.memwb", 4'd5, 5'b00011);
    chk("lw.memwb.resultsrc", 32'(ResultSrc), 1);
    tick; Op = 7'b1100011; BranchTaken = 1'b1; #1;
    ctl("beq1.fetch", 4'd0, 5'b11100);
    tick; ctl("beq1.decode", 4'd1, 5'b00000);
    chk("beq1.imm", 32'(ImmSrc), 2);
    tick; ctl("beq1.branch", 4'd9, 5'b00101);
    chk("beq1.branchsig", 32'({Branch, ALUSrcA, ALUSrcB, ALUOp}), 32'(7'b1100001));
    BranchTaken = 1'b0; #1;
    chk("beq1.mealy_pcwrite", 32'(PCWrite), 0);
    tick; ctl("beq2.fetch", 4'd0, 5'b11100);
    tick; ctl("beq2.decode", 4'd1, 5'b00000);
    tick; ctl("beq2.branch", 4'd9, 5'b00001);
    tick; Op = 7'b1100111; #1;
    ctl("jalr.fetch", 4'd0, 5'b11100);
    tick; ctl("jalr.decode", 4'd1, 5'b00000);
    tick; ctl("jalr.jalr", 4'd11, 5'b00100);
    chk("jalr.resultsrc", 32'(ResultSrc), 2);
    tick; ctl("jalr.lnk", 4'd12, 5'b00000);
    chk("jalr.lnk.src", 32'({ALUSrcA, ALUSrcB}), 32'(4'b0110));
    tick; ctl("jalr.wb", 4'd8, 5'b00011);
    tick; Op = 7'b1101111; #1;
    ctl("jal.fetch", 4'd0, 5'b11100);
    tick; chk("jal.imm", 32'(ImmSrc), 3);
    tick; ctl("jal.jal", 4'd10, 5'b00100);
    chk("jal.src", 32'({ALUSrcA, ALUSrcB, ResultSrc}), 32'(6'b011000));
    tick; ctl("jal.wb", 4'd8, 5'b00011);
    tick; Op = 7'b0110111; #1;
    tick; ctl("lui.decode", 4'd1, 5'b00000);
    tick; ctl("lui.wb", 4'd13, 5'b00011);
    chk("lui.resultsrc", 32'(ResultSrc), 3);
    tick; Op = 7'b0010111; #1;
    tick; tick; ctl("auipc.wb", 4'd8, 5'b00011);
    tick; Op = 7'b0010011; #1;
    tick; tick; ctl("addi.execi", 4'd7, 5'b00000);
    chk("addi.sel", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'(6'b100111));
    tick; ctl("addi.wb", 4'd8, 5'b00011);
    tick; Op = 7'b0100011; #1;
    tick; chk("sw.imm", 32'(ImmSrc), 1);
    tick; ctl("sw.memadr", 4'd2, 5'b00000);
    tick; ctl("sw.memwr", 4'd4, 5'b10001);
    chk("sw.memwr.adr", 32'({AdrSrc, MemWrite}), 32'(2'b11));
    tick; ctl("sw.next", 4'd0, 5'b11100);
    tick; tick; mem_ready = 1'b0; #1;
    tick; ctl("sw2.wait1", 4'd4, 5'b10000);
    chk("sw2.wait1.adr", 32'({AdrSrc, MemWrite}), 32'(2'b11));
    tick; ctl("sw2.wait2", 4'd4, 5'b10000);
    rst = 1'b1; #1;
    chk("sw2.rst.strobes", 32'({mem_req, MemWrite, retire}), 0);
    tick; rst = 1'b0; #1;
    ctl("sw2.after_rst", 4'd0, 5'b10000);
    mem_ready = 1'b1; Op = 7'b0000000; #1;
    tick; ctl("trap.decode", 4'd1, 5'b00000);
    for (int i = 0; i < 10; i++) begin
      tick;
      ctl("trap.hold", 4'd14, 5'b00000);
      chk("trap.illegal", 32'({illegal, MemWrite}), 32'(2'b10));
    end
    rst = 1'b1; #1;
    tick; rst = 1'b0; #1;
    ctl("trap.cleared", 4'd0, 5'b11100);
    chk("trap.cleared.illegal", 32'(illegal), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
